// File: rtl/serial_out.sv
// serial_out: reads num_words RAM rows and shifts fields 0..feat of each row out one bit per
// accepted cycle over a valid/ready handshake, field 0 first, each field MSB first.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   start             one-cycle request, sampled only while idle
//   feat, num_words   active feature count and row count, latched when start is accepted
//   addr, rd_en       RAM read address / strobe (addr driven while busy)
//   rdata             RAM row, valid the cycle after rd_en
//   ser, ser_valid    serial bit and its valid flag
//   ser_ready         downstream accepts the presented bit this cycle
//   frame_start       high while the first bit of a row is presented
//   busy, done        transfer in progress / one-cycle completion pulse
module serial_out #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [3:0]            feat,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  ser,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  frame_start,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [3:0]            r_feat;
  logic [ADDR_WIDTH-1:0] r_num;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [8:0]            r_bit_cnt;
  logic                  r_first;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_more;
  logic [8:0]            w_row_bits;
  logic [DATA_WIDTH-1:0] w_row_ordered;

  assign w_accept   = (r_state == StShift) && ser_ready;
  assign w_last     = w_accept && (r_bit_cnt == 9'd1);
  // One extra bit so the compare stays correct when r_idx is all ones.
  assign w_more     = ({1'b0, r_idx} + 1'b1) < {1'b0, r_num};
  assign w_row_bits = 9'((32'(r_feat) + 32'd1) * LENGTH);

  // Place field 0 at the top of the shift register so a left shift yields field 0 first,
  // MSB first, then ascending fields.
  always_comb begin
    w_row_ordered = '0;
    for (int k = 0; k < int'(MAX_FEATURES + 1); k++) begin
      w_row_ordered[DATA_WIDTH - 1 - k * LENGTH -: LENGTH] = rdata[k * LENGTH +: LENGTH];
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = (num_words != '0) ? StFetch : StDone;
      StFetch: w_state_next = StLoad;
      StLoad:  w_state_next = StShift;
      StShift: if (w_last) w_state_next = w_more ? StFetch : StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    addr        = '0;
    rd_en       = 1'b0;
    ser         = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      StFetch: begin
        addr  = r_idx;
        rd_en = 1'b1;
        busy  = 1'b1;
      end
      StLoad: begin
        addr = r_idx;
        busy = 1'b1;
      end
      StShift: begin
        addr        = r_idx;
        busy        = 1'b1;
        ser_valid   = 1'b1;
        ser         = r_shift[DATA_WIDTH-1];
        frame_start = r_first;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latched request, word index, row shift register and bit counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_feat    <= '0;
      r_num     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_first   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_feat <= feat;
            r_num  <= num_words;
            r_idx  <= '0;
          end
        end
        StLoad: begin
          r_shift   <= w_row_ordered;
          r_bit_cnt <= w_row_bits;
          r_first   <= 1'b1;
        end
        StShift: begin
          if (w_accept) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - 9'd1;
            r_first   <= 1'b0;
          end
          if (w_last && w_more) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_out.sv
// tb_serial_out: directed bench for serial_out with a small registered RAM model.
module tb_serial_out;

  localparam int AW  = 12;
  localparam int LEN = 16;
  localparam int DW  = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    feat = '0;
  logic [AW-1:0] num_words = '0;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [DW-1:0] rdata = '0;
  logic          ser;
  logic          ser_valid;
  logic          ser_ready = 1'b1;
  logic          frame_start;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [8];

  int n_checks = 0;
  int n_fail   = 0;

  serial_out #(
    .ADDR_WIDTH  (AW),
    .MAX_FEATURES(15),
    .LENGTH      (LEN),
    .DATA_WIDTH  (DW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .feat       (feat),
    .num_words  (num_words),
    .addr       (addr),
    .rd_en      (rd_en),
    .rdata      (rdata),
    .ser        (ser),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  // RAM read data appears the cycle after rd_en.
  always @(posedge CLK) if (rd_en) rdata <= mem[addr[2:0]];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Start a transfer in the current cycle (cycle 0) and follow it cycle by cycle.
  task automatic run_xfer(input int f, input int nw, input int stall_lo, input int stall_hi,
                          input int restart_cyc, input int exp_done, input string name);
    bit q[$];
    int bi = 0;
    int bits_row;
    int done_cyc = -1;
    int done_cnt = 0;
    int busy_cnt = 0;
    int rd_cnt = 0;
    int first_valid = -1;
    bits_row = (f + 1) * LEN;
    for (int r = 0; r < nw; r++)
      for (int k = 0; k <= f; k++)
        for (int j = LEN - 1; j >= 0; j--) q.push_back(mem[r][k * LEN + j]);

    feat      = 4'(f);
    num_words = AW'(nw);
    start     = 1'b1;
    ser_ready = 1'b1;
    for (int c = 1; c <= exp_done + 4; c++) begin
      step();
      start     = 1'b0;
      ser_ready = !(c >= stall_lo && c <= stall_hi);
      if (c == restart_cyc) begin
        start     = 1'b1;
        feat      = 4'(f + 3);
        num_words = AW'(nw + 3);
      end
      if (rd_en) begin
        check_eq({name, "_addr"}, 32'(addr), rd_cnt);
        rd_cnt++;
      end
      if (ser_valid) begin
        if (first_valid < 0) first_valid = c;
        if (bi < q.size()) begin
          check_eq({name, "_ser"}, 32'(ser), 32'(q[bi]));
          check_eq({name, "_frame"}, 32'(frame_start), 32'(bi % bits_row == 0));
        end else begin
          check_eq({name, "_overrun"}, bi, q.size());
        end
        if (ser_ready) bi++;
      end else begin
        check_eq({name, "_ser_idle"}, 32'(ser), 0);
        check_eq({name, "_frame_idle"}, 32'(frame_start), 0);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        check_eq({name, "_busy_at_done"}, 32'(busy), 0);
      end
    end
    start = 1'b0;
    check_eq({name, "_done_cycle"}, done_cyc, exp_done);
    check_eq({name, "_done_count"}, done_cnt, 1);
    check_eq({name, "_bits"}, bi, q.size());
    check_eq({name, "_reads"}, rd_cnt, nw);
    check_eq({name, "_busy_cycles"}, busy_cnt, (nw == 0) ? 0 : exp_done - 1);
    check_eq({name, "_first_valid"}, first_valid, (nw == 0) ? -1 : 3);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = {16{16'hDEAD}};

    // Reset state.
    step();
    step();
    check_eq("reset_outputs", 32'({addr, rd_en, ser, ser_valid, frame_start, busy, done}), 0);
    RST = 1'b0;
    step();

    // Single row, single field: A5C3 on cycles 3..18, done at 19.
    mem[0][15:0] = 16'hA5C3;
    run_xfer(0, 1, 0, -1, -1, 19, "t1");

    // Same, with ready low on cycles 5..8: done four cycles later.
    run_xfer(0, 1, 5, 8, -1, 23, "t2");

    // Two fields, three rows: 3 + 3*(32+2) - 2 = 103.
    for (int i = 0; i < 8; i++) begin
      mem[i][15:0]  = 16'(16'h0001 + i);
      mem[i][31:16] = 16'(16'h8000 + i);
    end
    run_xfer(1, 3, 0, -1, -1, 103, "t3");

    // Zero rows: straight to DONE at cycle 1.
    run_xfer(0, 0, 0, -1, -1, 1, "t4");

    // Reset while the 10th bit (cycle 12) of a three-row transfer is presented.
    feat      = 4'd0;
    num_words = AW'(3);
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 12; c++) step();
    check_eq("t5_pre_valid", 32'(ser_valid), 1);
    check_eq("t5_pre_bit", 32'(ser), 32'(mem[0][6]));
    RST = 1'b1;
    step();
    check_eq("t5_abort_outputs", 32'({addr, rd_en, ser, ser_valid, frame_start, busy, done}), 0);
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("t5_no_done", 32'({done, busy, ser_valid}), 0);
    end
    run_xfer(0, 3, 0, -1, -1, 55, "t5");

    // Second start mid-shift with different feat/num_words: 3 + 2*18 - 2 = 37.
    run_xfer(0, 2, 0, -1, 10, 37, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
